// File: rtl/dca_matrix_pkg.sv
// Shared DCA matrix definitions: LSU constants, row-assembler state encoding,
// and the row-index width helper.
package dca_matrix_pkg;

  localparam int LSU_BW_ADDR      = 32;
  localparam int LSU_BW_WORD      = 32;
  localparam int LSU_BW_BYTE_MASK = LSU_BW_WORD / 8;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } asm_state_t;

  // A single-row matrix still needs a one-bit index port.
  function automatic int row_index_width(input int num_row);
    return (num_row <= 1) ? 1 : $clog2(num_row);
  endfunction

endpackage

// File: rtl/dca_matrix_row_assembler_if.sv
// Beat-in / row-out handshake bundle of the row assembler.
interface dca_matrix_row_assembler_if #(
  parameter int BW_ROW_BUFFER = 256,
  parameter int BW_ROW_INDEX  = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [BW_ROW_BUFFER-1:0] in_data;
  logic [BW_ROW_BUFFER-1:0] in_mask;
  logic                     in_last_beat;
  logic                     in_last_row;
  logic                     row_valid;
  logic                     row_ready;
  logic [BW_ROW_BUFFER-1:0] row_data;
  logic [BW_ROW_INDEX-1:0]  row_index;
  logic                     row_last;
  logic                     matrix_done;
  logic                     overlap_err;

  modport master (
    output in_valid, in_data, in_mask, in_last_beat, in_last_row, row_ready,
    input  in_ready, row_valid, row_data, row_index, row_last, matrix_done, overlap_err
  );

  modport slave (
    input  in_valid, in_data, in_mask, in_last_beat, in_last_row, row_ready,
    output in_ready, row_valid, row_data, row_index, row_last, matrix_done, overlap_err
  );
endinterface

// File: rtl/dca_masked_merge.sv
// Bitwise masked merge: bits selected by mask come from data, the rest from old.
module dca_masked_merge #(
  parameter int BW = 256
) (
  input  logic [BW-1:0] old,
  input  logic [BW-1:0] data,
  input  logic [BW-1:0] mask,
  output logic [BW-1:0] merged
);
  assign merged = (old & ~mask) | (data & mask);
endmodule

// File: rtl/dca_matrix_row_assembler.sv
// Assembles shifted, masked LSU beats into full matrix rows and hands them out.
// Optional overlap detection: define DCA_ROW_ASSEMBLER_OVERLAP_CHECK_EN.
//
// state | meaning
// ACCUM | accepting beats, merging them into the row register
// EMIT  | assembled row presented, waiting for row_ready
module dca_matrix_row_assembler
  import dca_matrix_pkg::*;
#(
  parameter int BW_ROW_BUFFER = 256,
  parameter int MAX_NUM_ROW   = 16,
  localparam int BW_ROW_INDEX = row_index_width(MAX_NUM_ROW)
) (
  input logic                      clk,
  input logic                      rstnn,
  dca_matrix_row_assembler_if.slave bus
);

  asm_state_t               state_q, state_d;
  logic [BW_ROW_BUFFER-1:0] row_q;
  logic [BW_ROW_BUFFER-1:0] merged;
  logic [BW_ROW_INDEX-1:0]  index_q;
  logic                     last_q;
  logic                     done_q;
  logic                     beat_acc;
  logic                     row_acc;

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.row_valid = (state_q == EMIT);
  assign beat_acc      = bus.in_valid & bus.in_ready;
  assign row_acc       = bus.row_valid & bus.row_ready;

  dca_masked_merge #(.BW(BW_ROW_BUFFER)) u_merge (
    .old    (row_q),
    .data   (bus.in_data),
    .mask   (bus.in_mask),
    .merged (merged)
  );

  always_ff @(posedge clk) begin
    if (!rstnn) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: if (beat_acc && bus.in_last_beat) state_d = EMIT;
      EMIT:  if (bus.row_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      row_q   <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= row_acc & last_q;
      if (beat_acc) begin
        row_q <= merged;
        if (bus.in_last_beat) last_q <= bus.in_last_row;
      end else if (row_acc) begin
        row_q <= '0;
        // Index restarts on the final row or when the row count wraps.
        if (last_q || index_q == BW_ROW_INDEX'(MAX_NUM_ROW - 1)) index_q <= '0;
        else                                                     index_q <= index_q + 1'b1;
      end
    end
  end

  assign bus.row_data    = row_q;
  assign bus.row_index   = index_q;
  assign bus.row_last    = last_q;
  assign bus.matrix_done = done_q;

`ifdef DCA_ROW_ASSEMBLER_OVERLAP_CHECK_EN
  logic [BW_ROW_BUFFER-1:0] written_mask;
  logic                     overlap_q;

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      written_mask <= '0;
      overlap_q    <= 1'b0;
    end else if (beat_acc) begin
      written_mask <= written_mask | bus.in_mask;
      if ((bus.in_mask & written_mask) != '0) overlap_q <= 1'b1;
    end else if (row_acc) begin
      written_mask <= '0;
    end
  end

  assign bus.overlap_err = overlap_q;
`else
  assign bus.overlap_err = 1'b0;
`endif

endmodule

// File: doc/dca_matrix_row_assembler.md
DCA_MATRIX_ROW_ASSEMBLER -- requirements
Module: dca_matrix_row_assembler

Interface
REQ-001 The block SHALL have parameter BW_ROW_BUFFER, default 256, giving the row-buffer width in bits.
REQ-002 The block SHALL have parameter MAX_NUM_ROW, default 16, giving the maximum matrix rows; BW_ROW_INDEX = clog2(MAX_NUM_ROW).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rstnn, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a shifted beat is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the beat is accepted this cycle.
REQ-007 The block SHALL have port in_data, input, BW_ROW_BUFFER bits: the shifted read data from the upstream LSU stage.
REQ-008 The block SHALL have port in_mask, input, BW_ROW_BUFFER bits: the shifted valid-bit mask.
REQ-009 The block SHALL have port in_last_beat, input, 1 bit: this beat completes the current row.
REQ-010 The block SHALL have port in_last_row, input, 1 bit: the current row is the final row of the matrix.
REQ-011 The block SHALL have port row_valid, output, 1 bit: an assembled row is presented.
REQ-012 The block SHALL have port row_ready, input, 1 bit: the consumer accepts the row.
REQ-013 The block SHALL have port row_data, output, BW_ROW_BUFFER bits: the assembled row.
REQ-014 The block SHALL have port row_index, output, BW_ROW_INDEX bits: the index of the presented row.
REQ-015 The block SHALL have port row_last, output, 1 bit: the presented row is the final row.
REQ-016 The block SHALL have port matrix_done, output, 1 bit: one-cycle pulse when the final row is accepted.
REQ-017 The block SHALL have port overlap_err, output, 1 bit: sticky overlap flag (see Configuration).

Function
REQ-018 The FSM SHALL have two states, ACCUM and EMIT; ACCUM is the reset state.
REQ-019 In ACCUM, in_ready SHALL be 1; in EMIT, in_ready SHALL be 0.
REQ-020 On an accepted beat (in_valid&in_ready), the row register SHALL be updated as row = (row & ~in_mask) | (in_data & in_mask).
REQ-021 An accepted beat with in_last_beat=1 SHALL load the merged value into the row register, capture in_last_row into row_last, and move the FSM to EMIT.
REQ-022 row_valid SHALL equal (state==EMIT), which gives one-cycle latency from acceptance of the last beat to row_valid.
REQ-023 In EMIT, row_data, row_index and row_last SHALL stay stable until row_ready=1.
REQ-024 On row acceptance (row_valid&row_ready), the row register SHALL clear to 0 and the FSM SHALL return to ACCUM.
REQ-025 On row acceptance, row_index SHALL become 0 if row_last=1 or row_index==MAX_NUM_ROW-1, and row_index+1 otherwise.
REQ-026 On row acceptance with row_last=1, matrix_done SHALL pulse high for exactly one cycle.
REQ-027 An accepted beat with in_mask=0 SHALL leave the row register unchanged; if in_last_beat=1, the FSM SHALL still move to EMIT.
REQ-028 A single beat carrying both in_last_beat and in_last_row SHALL produce one row with row_last=1.
REQ-029 Data SHALL have no combinational path from in_* to row_*; the only combinational path SHALL be state to in_ready.

Reset
REQ-030 While rstnn=0 at a clock edge, the block SHALL set state=ACCUM, row register=0, row_index=0, row_last=0, matrix_done=0 and overlap_err=0.
REQ-031 A reset asserted mid-row or in EMIT SHALL discard the partial or presented row without emitting it.

Configuration
REQ-032 With DCA_ROW_ASSEMBLER_OVERLAP_CHECK_EN defined, overlap_err SHALL set on any accepted beat where (in_mask & written_mask)!=0.
REQ-033 With the macro defined, written_mask SHALL accumulate in_mask per row, clear on row acceptance, and overlap_err SHALL stay set until reset.
REQ-034 Without DCA_ROW_ASSEMBLER_OVERLAP_CHECK_EN, overlap_err SHALL be tied to 0 and written_mask SHALL not exist.

Structure
REQ-035 The FSM state encoding and the row-index width function SHALL live in the shared package dca_matrix_pkg, alongside the LSU defines.
REQ-036 The mask-merge datapath SHALL be a sub-module, dca_masked_merge (combinational: old, data, mask to merged).
REQ-037 No other sub-modules SHALL be used.

Verification
REQ-038 Two beats, mask 0x00FF data 0x1234 then mask 0xFF00 data 0xAB00, with last on the second -> row_data 0xAB34, row_valid the next cycle, row_index 0.
REQ-039 row_ready held 0 for 5 cycles in EMIT -> in_ready=0, and row_data/row_index held stable throughout.
REQ-040 Three rows with in_last_row on the third -> row_index 0,1,2; row_last only on row 2; matrix_done a single pulse; next row_index 0.
REQ-041 MAX_NUM_ROW=4 with 5 rows and no last_row -> row_index sequence 0,1,2,3,0.
REQ-042 rstnn=0 after one beat of a two-beat row -> after reset, no row_valid; the next row starts from row register 0.
REQ-043 Macro defined, with overlapping masks 0x0F0 and 0x0FF in one row -> overlap_err=1 sticky; macro undefined -> overlap_err=0.
